// File: rtl/mpu_row_feeder.sv
// Edge feeder for one row of the MPU systolic array: buffers float operands in a small
// FIFO and, after a per-row skew delay, streams a fixed count of them into a PE.
module mpu_row_feeder #(
    parameter int DEPTH = 8,
    parameter int SKEW  = 0,
    parameter int LEN_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic                     start,
    input  logic [LEN_W-1:0]         length,
    output logic [31:0]              float_out,
    output logic                     ready_out,
    input  logic                     ack_in,
    output logic                     busy,
    output logic                     done,
    output logic                     error_out,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SKEW_W = (SKEW > 1) ? $clog2(SKEW) : 1;
    localparam logic [SKEW_W-1:0] SKEW_LOAD = (SKEW > 0) ? SKEW_W'(SKEW - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKEW_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    localparam state_t FIRST_STATE = (SKEW > 0) ? S_SKEW_WAIT : S_STREAM;

    state_t              state, state_next;
    logic [LEN_W-1:0]    remaining, remaining_next;
    logic [SKEW_W-1:0]   skew_cnt, skew_next;

    logic [31:0]         mem [DEPTH];
    logic [PTR_W-1:0]    wptr, rptr, rptr_next;
    logic [CNT_W-1:0]    count, count_next, count_after_pop;
    logic                armed;
    logic                push, pop;
    logic [31:0]         head_next;

    logic                ready_q, ready_next;
    logic [31:0]         data_q, data_next;
    logic                error_q;

    always_comb begin
        push            = load_valid && load_ready;
        pop             = ready_q && ack_in;
        rptr_next       = rptr + PTR_W'(pop);
        count_after_pop = count - CNT_W'(pop);
        count_next      = count_after_pop + CNT_W'(push);
        // When the FIFO drains to nothing this cycle, the incoming word becomes the new head.
        head_next       = (count_after_pop == '0) ? load_data : mem[rptr_next];
    end

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        skew_next      = skew_cnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    remaining_next = length;
                    skew_next      = SKEW_LOAD;
                    state_next     = (length == '0) ? S_DONE : FIRST_STATE;
                end
            end
            S_SKEW_WAIT: begin
                if (skew_cnt == '0) state_next = S_STREAM;
                else                skew_next  = skew_cnt - 1'b1;
            end
            S_STREAM: begin
                if (pop) begin
                    remaining_next = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The head register is reloaded every cycle, so a stalled PE sees a stable word.
    always_comb begin
        ready_next = (state == S_STREAM) && (state_next == S_STREAM) && (count_next != '0);
        data_next  = ready_next ? head_next : '0;
    end

    // NOTE: operand storage has no reset; emptiness is tracked by count, and float_out is
    // driven from a separately reset head register, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            skew_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            armed     <= 1'b0;
            ready_q   <= 1'b0;
            data_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            skew_cnt  <= skew_next;
            wptr      <= wptr + PTR_W'(push);
            rptr      <= rptr_next;
            count     <= count_next;
            armed     <= 1'b1;
            ready_q   <= ready_next;
            data_q    <= data_next;
            error_q   <= start && ((state == S_SKEW_WAIT) || (state == S_STREAM));
        end
    end

    assign load_ready = armed && (count != CNT_W'(DEPTH));
    assign float_out  = data_q;
    assign ready_out  = ready_q;
    assign busy       = (state == S_SKEW_WAIT) || (state == S_STREAM);
    assign done       = (state == S_DONE);
    assign error_out  = error_q;
    assign fill       = count;

endmodule
